// File: rtl/tx_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tx_scan_sequencer
//
// Frame-level transmit scheduler. Walks every scan line of a frame and, inside
// each line, every focus zone 0..focus_max. Each (line, focus) pair is one
// "firing". A firing is made of consecutive phases:
//
//   PR   (TX_CYC cycles)           Pr_Gate  = 1
//   RX   (RX_CYC cycles)           RX_Gate  = 1
//   WAIT (T - TX_CYC - RX_CYC)     all gates low; skipped when T <= TX+RX
//   END  (END_CYC cycles)          End_Gate = 1
//   GAP  (GAP_CYC cycles)          all gates low
//   ENV  (ENV_CYC cycles)          Envelop  = 1
//
// T is the line period, chosen per firing at PR entry: the far period for
// focus 2/3, the near period for focus 0/1. Firings run back to back; after
// the last ENV of the frame frame_done pulses for one cycle and the sequencer
// either returns to IDLE or (continuous mode) restarts the frame immediately.
// abort drops everything to IDLE on the next cycle without a frame_done.
//
// Every phase is expected to last at least one cycle (all *_CYC >= 1).
//
// Ports
//   clk_100M         in   system clock
//   reset_n          in   synchronous, active-low reset
//   frame_start      in   single-cycle frame request (ignored while busy)
//   abort            in   synchronous stop request (wins over frame_start)
//   cfg_line_count   in   [7:0]  lines per frame, 0 = empty frame
//   cfg_focus_max    in   [1:0]  highest focus index fired per line
//   cfg_continuous   in   auto-restart the frame after frame_done
//   cfg_period_near  in   [31:0] line period for focus 0/1
//   cfg_period_far   in   [31:0] line period for focus 2/3
//   Pr_Gate          out  pulser enable
//   RX_Gate          out  receive window
//   End_Gate         out  end-of-line marker
//   Envelop          out  end-of-firing strobe
//   Line_Num         out  [7:0] line index of the current firing
//   Focus_Num        out  [1:0] focus index of the current firing
//   busy             out  frame in progress
//   frame_done       out  single-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module tx_scan_sequencer #(
    parameter int unsigned TX_CYC  = 3000,
    parameter int unsigned RX_CYC  = 250,
    parameter int unsigned END_CYC = 80,
    parameter int unsigned GAP_CYC = 10,
    parameter int unsigned ENV_CYC = 5
) (
    input  logic        clk_100M,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [7:0]  cfg_line_count,
    input  logic [1:0]  cfg_focus_max,
    input  logic        cfg_continuous,
    input  logic [31:0] cfg_period_near,
    input  logic [31:0] cfg_period_far,
    output logic        Pr_Gate,
    output logic        RX_Gate,
    output logic        End_Gate,
    output logic        Envelop,
    output logic [7:0]  Line_Num,
    output logic [1:0]  Focus_Num,
    output logic        busy,
    output logic        frame_done
);

    // Phase lengths as 32-bit quantities so all counter math is unsigned 32-bit.
    localparam logic [31:0] TX_LEN   = 32'(TX_CYC);
    localparam logic [31:0] RX_LEN   = 32'(RX_CYC);
    localparam logic [31:0] END_LEN  = 32'(END_CYC);
    localparam logic [31:0] GAP_LEN  = 32'(GAP_CYC);
    localparam logic [31:0] ENV_LEN  = 32'(ENV_CYC);
    localparam logic [31:0] TXRX_LEN = TX_LEN + RX_LEN;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PR   = 3'd1,
        S_RX   = 3'd2,
        S_WAIT = 3'd3,
        S_END  = 3'd4,
        S_GAP  = 3'd5,
        S_ENV  = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] period_reg, period_next;
    logic [7:0]  line_reg, line_next;
    logic [1:0]  focus_reg, focus_next;

    // Frame configuration, frozen for the duration of a frame.
    logic [7:0]  line_count_reg, line_count_next;
    logic [1:0]  focus_max_reg, focus_max_next;
    logic        continuous_reg, continuous_next;

    logic        done_next;

    // Length of the phase currently being executed, and end-of-phase flag.
    logic [31:0] state_dur;
    logic        state_last;
    logic        wait_skip;
    logic        last_line;

    // -------------------------------------------------------------------------
    // Phase length decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_dur = 32'd1;
        case (state_reg)
            S_PR:    state_dur = TX_LEN;
            S_RX:    state_dur = RX_LEN;
            S_WAIT:  state_dur = period_reg - TXRX_LEN;
            S_END:   state_dur = END_LEN;
            S_GAP:   state_dur = GAP_LEN;
            S_ENV:   state_dur = ENV_LEN;
            default: state_dur = 32'd1;
        endcase
    end

    // The counter is cleared on every state entry, so the phase ends when it
    // reaches duration-1.
    assign state_last = (cnt_reg == state_dur - 32'd1);

    // A period that does not extend past PR+RX leaves no room for WAIT.
    assign wait_skip = (period_reg <= TXRX_LEN);

    // 9-bit compare avoids the line_count-1 underflow question entirely.
    assign last_line = !(({1'b0, line_reg} + 9'd1) < {1'b0, line_count_reg});

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 32'd1;
        period_next     = period_reg;
        line_next       = line_reg;
        focus_next      = focus_reg;
        line_count_next = line_count_reg;
        focus_max_next  = focus_max_reg;
        continuous_next = continuous_reg;
        done_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // abort has priority over a simultaneous frame_start.
                if (frame_start && !abort) begin
                    line_count_next = cfg_line_count;
                    focus_max_next  = cfg_focus_max;
                    continuous_next = cfg_continuous;
                    if (cfg_line_count != 8'd0) begin
                        state_next = S_PR;
                        line_next  = 8'd0;
                        focus_next = 2'd0;
                    end else begin
                        // Empty frame: complete immediately, never go busy.
                        done_next = 1'b1;
                    end
                end
            end

            default: begin
                if (abort) begin
                    // Line/focus deliberately keep their values so the host
                    // can see where the frame was stopped.
                    state_next = S_IDLE;
                end else if (state_last) begin
                    case (state_reg)
                        S_PR:   state_next = S_RX;
                        S_RX:   state_next = wait_skip ? S_END : S_WAIT;
                        S_WAIT: state_next = S_END;
                        S_END:  state_next = S_GAP;
                        S_GAP:  state_next = S_ENV;
                        S_ENV: begin
                            if (focus_reg < focus_max_reg) begin
                                state_next = S_PR;
                                focus_next = focus_reg + 2'd1;
                            end else if (!last_line) begin
                                state_next = S_PR;
                                line_next  = line_reg + 8'd1;
                                focus_next = 2'd0;
                            end else begin
                                done_next = 1'b1;
                                if (continuous_reg) begin
                                    // Restart in the same cycle as frame_done
                                    // using freshly sampled configuration.
                                    line_count_next = cfg_line_count;
                                    focus_max_next  = cfg_focus_max;
                                    continuous_next = cfg_continuous;
                                    line_next       = 8'd0;
                                    focus_next      = 2'd0;
                                    // A re-latched empty frame has nothing to
                                    // fire, so it ends the run instead.
                                    state_next = (cfg_line_count != 8'd0) ? S_PR : S_IDLE;
                                end else begin
                                    state_next = S_IDLE;
                                end
                            end
                        end
                        default: state_next = S_IDLE;
                    endcase
                end
            end
        endcase

        // No state has a self-re-entry, so any state change is an entry.
        if (state_next != state_reg) begin
            cnt_next = 32'd0;
        end

        // Period is chosen for the firing being entered, using its focus index.
        if ((state_next == S_PR) && (state_reg != S_PR)) begin
            period_next = focus_next[1] ? cfg_period_far : cfg_period_near;
        end
    end

    // -------------------------------------------------------------------------
    // Registers. Gates are decoded from the next state so they line up exactly
    // with the state they belong to while still coming straight from flops.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100M) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 32'd0;
            period_reg     <= 32'd0;
            line_reg       <= 8'd0;
            focus_reg      <= 2'd0;
            line_count_reg <= 8'd0;
            focus_max_reg  <= 2'd0;
            continuous_reg <= 1'b0;
            Pr_Gate        <= 1'b0;
            RX_Gate        <= 1'b0;
            End_Gate       <= 1'b0;
            Envelop        <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            period_reg     <= period_next;
            line_reg       <= line_next;
            focus_reg      <= focus_next;
            line_count_reg <= line_count_next;
            focus_max_reg  <= focus_max_next;
            continuous_reg <= continuous_next;
            Pr_Gate        <= (state_next == S_PR);
            RX_Gate        <= (state_next == S_RX);
            End_Gate       <= (state_next == S_END);
            Envelop        <= (state_next == S_ENV);
            busy           <= (state_next != S_IDLE);
            frame_done     <= done_next;
        end
    end

    assign Line_Num  = line_reg;
    assign Focus_Num = focus_reg;

endmodule

// File: tb/tb_tx_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tx_scan_sequencer
//
// Directed bench for tx_scan_sequencer with short phase lengths. A timing
// model describes each firing by its offset from the firing start and derives
// every output from that offset; a compare process checks the DUT against it
// on every cycle. Directed scenarios add literal, hand-computed timing checks.
// -----------------------------------------------------------------------------
module tb_tx_scan_sequencer;

    localparam int unsigned TXC  = 4;
    localparam int unsigned RXC  = 2;
    localparam int unsigned ENDC = 3;
    localparam int unsigned GAPC = 2;
    localparam int unsigned ENVC = 1;

    logic        clk_100M = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_line_count = 8'd0;
    logic [1:0]  cfg_focus_max = 2'd0;
    logic        cfg_continuous = 1'b0;
    logic [31:0] cfg_period_near = 32'd0;
    logic [31:0] cfg_period_far = 32'd0;
    logic        Pr_Gate, RX_Gate, End_Gate, Envelop, busy, frame_done;
    logic [7:0]  Line_Num;
    logic [1:0]  Focus_Num;

    always #5 clk_100M = ~clk_100M;

    tx_scan_sequencer #(
        .TX_CYC(TXC), .RX_CYC(RXC), .END_CYC(ENDC), .GAP_CYC(GAPC), .ENV_CYC(ENVC)
    ) dut (
        .clk_100M(clk_100M), .reset_n(reset_n), .frame_start(frame_start), .abort(abort),
        .cfg_line_count(cfg_line_count), .cfg_focus_max(cfg_focus_max),
        .cfg_continuous(cfg_continuous), .cfg_period_near(cfg_period_near),
        .cfg_period_far(cfg_period_far), .Pr_Gate(Pr_Gate), .RX_Gate(RX_Gate),
        .End_Gate(End_Gate), .Envelop(Envelop), .Line_Num(Line_Num),
        .Focus_Num(Focus_Num), .busy(busy), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- timing model ----------------
    logic        m_busy = 1'b0, m_done = 1'b0, m_cont = 1'b0;
    logic [7:0]  m_line = 8'd0, m_lc = 8'd0;
    logic [1:0]  m_focus = 2'd0, m_fm = 2'd0;
    int unsigned m_off = 0, m_T = 0;

    function automatic int unsigned base_len(input int unsigned t);
        return (t > TXC + RXC) ? t : TXC + RXC;
    endfunction

    function automatic int unsigned fire_len(input int unsigned t);
        return base_len(t) + ENDC + GAPC + ENVC;
    endfunction

    task automatic m_fire(input logic [7:0] l, input logic [1:0] f);
        m_line  = l;
        m_focus = f;
        m_T     = f[1] ? cfg_period_far : cfg_period_near;
        m_off   = 0;
        m_busy  = 1'b1;
    endtask

    always @(posedge clk_100M) begin
        cyc = cyc + 1;
        m_done = 1'b0;
        if (!reset_n) begin
            m_busy = 1'b0; m_line = 8'd0; m_focus = 2'd0; m_off = 0;
        end else if (!m_busy) begin
            if (frame_start && !abort) begin
                m_lc = cfg_line_count; m_fm = cfg_focus_max; m_cont = cfg_continuous;
                if (m_lc != 8'd0) m_fire(8'd0, 2'd0);
                else m_done = 1'b1;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else begin
            m_off = m_off + 1;
            if (m_off == fire_len(m_T)) begin
                if (m_focus < m_fm) begin
                    m_fire(m_line, m_focus + 2'd1);
                end else if (int'(m_line) + 1 < int'(m_lc)) begin
                    m_fire(m_line + 8'd1, 2'd0);
                end else begin
                    m_done = 1'b1;
                    if (m_cont) begin
                        m_lc = cfg_line_count; m_fm = cfg_focus_max; m_cont = cfg_continuous;
                        if (m_lc != 8'd0) m_fire(8'd0, 2'd0);
                        else m_busy = 1'b0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + event recording ----------------
    logic [13:0] exp_v, act_v;
    logic        prev_pr = 1'b0, prev_end = 1'b0;
    int pr_q[$];
    int end_q[$];
    int fd_q[$];

    always @(negedge clk_100M) begin
        if (cyc >= 1) begin
            int unsigned b;
            b = base_len(m_T);
            exp_v = {m_busy && (m_off < TXC),
                     m_busy && (m_off >= TXC) && (m_off < TXC + RXC),
                     m_busy && (m_off >= b) && (m_off < b + ENDC),
                     m_busy && (m_off >= b + ENDC + GAPC) && (m_off < b + ENDC + GAPC + ENVC),
                     m_busy, m_done, m_line, m_focus};
            act_v = {Pr_Gate, RX_Gate, End_Gate, Envelop, busy, frame_done, Line_Num, Focus_Num};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL cycle %0d outputs{pr,rx,end,env,busy,done,line,focus}: got %b required %b",
                         cyc, act_v, exp_v);
            end
            if (Pr_Gate && !prev_pr) pr_q.push_back(cyc);
            if (End_Gate && !prev_end) end_q.push_back(cyc);
            if (frame_done) fd_q.push_back(cyc);
            prev_pr  = Pr_Gate;
            prev_end = End_Gate;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -100000;
    endfunction

    task automatic clear_q();
        pr_q.delete(); end_q.delete(); fd_q.delete();
    endtask

    task automatic pulse(input logic [7:0] lc, input logic [1:0] fm, input logic cont,
                         input logic [31:0] near, input logic [31:0] far, output int k);
        cfg_line_count = lc; cfg_focus_max = fm; cfg_continuous = cont;
        cfg_period_near = near; cfg_period_far = far;
        frame_start = 1'b1;
        k = cyc;
        tick();
        frame_start = 1'b0;
        $display("txn cyc=%0d frame_start lc=%0d fm=%0d cont=%0d near=%0d far=%0d",
                 k, lc, fm, cont, near, far);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin tick(); n = n + 1; end
        check(name, int'(busy), 0);
        tick(); tick();
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("txn cyc=%0d abort", cyc - 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        int k2;

        // Reset held 5 cycles.
        repeat (3) tick();
        check("reset outputs", int'({Pr_Gate, RX_Gate, End_Gate, Envelop, busy, frame_done, Line_Num, Focus_Num}), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // 1: 2 lines x 2 foci, T=20 -> four 26-cycle firings, done at +105.
        clear_q();
        pulse(8'd2, 2'd1, 1'b0, 32'd20, 32'd40, k);
        wait_idle("s1 idle timeout", 300);
        check("s1 pr count", pr_q.size(), 4);
        check("s1 pr latency", at(pr_q, 0) - k, 1);
        check("s1 firing 2 start", at(pr_q, 1) - k, 27);
        check("s1 firing 4 start", at(pr_q, 3) - k, 79);
        check("s1 frame_done", at(fd_q, 0) - k, 105);

        // 2: near/far periods -> 26,26,46,46.
        clear_q();
        pulse(8'd1, 2'd3, 1'b0, 32'd20, 32'd40, k);
        wait_idle("s2 idle timeout", 400);
        check("s2 len f0", at(pr_q, 1) - at(pr_q, 0), 26);
        check("s2 len f1", at(pr_q, 2) - at(pr_q, 1), 26);
        check("s2 len f2", at(pr_q, 3) - at(pr_q, 2), 46);
        check("s2 len f3", at(fd_q, 0) - at(pr_q, 3), 46);
        check("s2 end offset f0", at(end_q, 0) - at(pr_q, 0), 20);
        check("s2 end offset f2", at(end_q, 2) - at(pr_q, 2), 40);

        // 3: short period skips WAIT -> 12-cycle firing, End right after RX.
        clear_q();
        pulse(8'd1, 2'd0, 1'b0, 32'd3, 32'd3, k);
        wait_idle("s3 idle timeout", 100);
        check("s3 end after rx", at(end_q, 0) - at(pr_q, 0), 6);
        check("s3 firing len", at(fd_q, 0) - at(pr_q, 0), 12);

        // 4: continuous; line_count change applies from the next frame.
        clear_q();
        pulse(8'd1, 2'd0, 1'b1, 32'd20, 32'd40, k);
        goto_cyc(k + 40);
        cfg_line_count = 8'd2;
        k2 = 0;
        while (fd_q.size() < 3 && k2 < 300) begin tick(); k2 = k2 + 1; end
        check("s4 frame_done count", fd_q.size(), 3);
        check("s4 busy held", int'(busy), 1);
        check("s4 done 1", at(fd_q, 0) - k, 27);
        check("s4 done 2", at(fd_q, 1) - k, 53);
        check("s4 done 3 (2 lines)", at(fd_q, 2) - k, 105);
        cfg_continuous = 1'b0;
        do_abort();
        check("s4 abort busy", int'(busy), 0);
        tick();

        // 5: abort in WAIT of firing (1,0).
        clear_q();
        pulse(8'd2, 2'd1, 1'b0, 32'd20, 32'd40, k);
        goto_cyc(k + 63);
        do_abort();
        check("s5 gates", int'({Pr_Gate, RX_Gate, End_Gate, Envelop}), 0);
        check("s5 busy", int'(busy), 0);
        check("s5 line hold", int'(Line_Num), 1);
        check("s5 focus hold", int'(Focus_Num), 0);
        tick(); tick();
        check("s5 no frame_done", fd_q.size(), 0);
        pulse(8'd2, 2'd1, 1'b0, 32'd20, 32'd40, k);
        check("s5 restart line", int'(Line_Num), 0);
        check("s5 restart focus", int'(Focus_Num), 0);
        check("s5 restart pr", int'(Pr_Gate), 1);
        tick(); tick();
        do_abort();
        tick();

        // 6a: empty frame -> frame_done next cycle, nothing else.
        clear_q();
        pulse(8'd0, 2'd0, 1'b0, 32'd20, 32'd40, k);
        check("s6 empty done", int'(frame_done), 1);
        check("s6 empty busy", int'(busy), 0);
        repeat (3) tick();
        check("s6 empty no pr", pr_q.size(), 0);

        // 6b: abort together with frame_start in IDLE -> ignored.
        cfg_line_count = 8'd1;
        abort = 1'b1;
        pulse(8'd1, 2'd0, 1'b0, 32'd20, 32'd40, k);
        abort = 1'b0;
        check("s6 abort wins", int'(busy), 0);
        tick();

        // 6c: frame_start while busy has no effect.
        clear_q();
        pulse(8'd1, 2'd0, 1'b0, 32'd20, 32'd40, k);
        goto_cyc(k + 5);
        pulse(8'd3, 2'd3, 1'b0, 32'd50, 32'd50, k2);
        wait_idle("s6 idle timeout", 100);
        check("s6 busy start pr count", pr_q.size(), 1);
        check("s6 busy start done", at(fd_q, 0) - k, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_scan_sequencer.md
Name: tx_scan_sequencer

Overview:
Frame-level scheduler for the transmit path. It steps through every scan line and every focus zone within each line. For each firing it generates the Pr_Gate / RX_Gate / End_Gate / Envelop timing and publishes the current Line_Num and Focus_Num. It sits between the host configuration registers and the pulser/receiver front end, and replaces the free-running per-line timer with a start/stop-controlled frame sequencer.

Parameters:
TX_CYC, 3000, Pr_Gate duration in clk_100M cycles (30 us)
RX_CYC, 250, RX_Gate duration in cycles
END_CYC, 80, End_Gate duration in cycles
GAP_CYC, 10, cycles between End_Gate falling and Envelop rising
ENV_CYC, 5, Envelop pulse width in cycles

Ports:
clk_100M  in  1  system clock, 100 MHz
reset_n  in  1  synchronous active-low reset
frame_start  in  1  single-cycle request to begin a frame
abort  in  1  synchronous stop request
cfg_line_count  in  8  lines per frame (0 = empty frame)
cfg_focus_max  in  2  highest focus index fired per line (zones = cfg_focus_max+1)
cfg_continuous  in  1  1 = auto-restart the frame after frame_done
cfg_period_near  in  32  line period in cycles for focus 0/1
cfg_period_far  in  32  line period in cycles for focus 2/3
Pr_Gate  out  1  pulser enable
RX_Gate  out  1  receive window
End_Gate  out  1  end-of-line marker
Envelop  out  1  end-of-firing strobe
Line_Num  out  8  current line index
Focus_Num  out  2  current focus index
busy  out  1  frame in progress
frame_done  out  1  single-cycle pulse at frame completion

Behaviour:
- Clocking and reset: one clock, clk_100M. reset_n is synchronous and active-low.
  - While reset_n=0: state=IDLE and every output is 0, including Line_Num, Focus_Num, busy and frame_done.
- All outputs are registered.
- States: IDLE, PR, RX, WAIT, END, GAP, ENV. A single 32-bit duration counter is cleared on every state entry.
- Latching:
  - cfg_line_count, cfg_focus_max and cfg_continuous are latched on an accepted frame_start.
  - The period is latched at each PR entry: T = cfg_period_far when the focus index bit1=1, otherwise cfg_period_near.
- IDLE:
  - frame_start=1 with cfg_line_count≠0 → PR on the next cycle, with busy=1, Line_Num=0, Focus_Num=0.
  - frame_start=1 with cfg_line_count=0 → frame_done=1 for one cycle; busy stays 0.
- State durations:
  - PR: TX_CYC cycles, Pr_Gate=1.
  - RX: RX_CYC cycles, RX_Gate=1.
  - WAIT: T−TX_CYC−RX_CYC cycles, all gates 0. If T ≤ TX_CYC+RX_CYC, WAIT is skipped and RX goes straight to END.
  - END: END_CYC cycles, End_Gate=1.
  - GAP: GAP_CYC cycles, all gates 0.
  - ENV: ENV_CYC cycles, Envelop=1.
- Firing length = max(T, TX_CYC+RX_CYC) + END_CYC + GAP_CYC + ENV_CYC cycles. Gates are mutually exclusive.
- On ENV exit, advance in this order:
  - If focus < focus_max: focus+1, same line.
  - Else if line < line_count−1: focus=0, line+1.
  - Else (frame complete): frame_done=1 for one cycle, in the cycle following the last ENV cycle.
- Frame complete, next step:
  - cfg_continuous latched=1 → re-latch cfg, line=0, focus=0, enter PR in that same cycle; busy stays 1.
  - cfg_continuous latched=0 → IDLE, busy=0.
- Line_Num and Focus_Num update only on PR entry and hold constant for the whole firing.
- frame_start while busy=1 is ignored.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all gates 0, busy=0, no frame_done.
  - Line_Num and Focus_Num hold their last values.
- Simultaneous abort and frame_start in IDLE: abort wins, so the frame_start is ignored.
- Counter arithmetic is unsigned 32-bit. Periods are not range-checked beyond the WAIT-skip rule.

Test Plan:
Bench overrides for all scenarios: TX_CYC=4, RX_CYC=2, END_CYC=3, GAP_CYC=2, ENV_CYC=1.
1. Reset held 5 cycles, then frame_start with line_count=2, focus_max=1, period_near=20, continuous=0 → expected response:
   - Pr_Gate rises 1 cycle after frame_start.
   - Four 26-cycle firings, in (line,focus) order (0,0),(0,1),(1,0),(1,1).
   - frame_done pulses at cycle 105 after frame_start; busy falls then.
2. focus_max=3, period_near=20, period_far=40, line_count=1 → firing lengths 26,26,46,46. End_Gate rises 20 cycles after Pr_Gate for focus 0/1 and 40 cycles after for focus 2/3.
3. period_near=3 (below TX+RX=6) → WAIT skipped. Firing = 12 cycles with RX_Gate directly followed by End_Gate.
4. continuous=1, line_count=1, focus_max=0, period_near=20 → frame_done every 26 cycles and busy stays 1. Changing cfg_line_count to 2 mid-frame takes effect only in the next frame.
5. abort asserted during WAIT of firing (1,0) → next cycle all gates 0, busy=0, no frame_done. Line_Num=1 and Focus_Num=0 hold. A new frame_start restarts at (0,0).
6. frame_start with line_count=0 → frame_done one cycle later, no gate activity. A frame_start pulse during busy → no effect on sequence timing.
